// File: rtl/seq_ctrl_pkg.sv
// Shared types and defaults for the run-detector sequencer.
//   ctrl_state_t : one-hot controller state (IDLE, SHIFT, DRAIN, DONE)
//   DEF_WORD_W   : default number of bits per input word
package seq_ctrl_pkg;

  localparam int unsigned DEF_WORD_W = 8;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    SHIFT = 4'b0010,
    DRAIN = 4'b0100,
    DONE  = 4'b1000
  } ctrl_state_t;

endpackage

// File: rtl/seq_piso.sv
// Parallel-in / serial-out shift register, MSB first.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture din (has priority over shift)
//   shift    : shift left by one, zero-filling the LSB
//   din      : parallel word
//   msb      : current most significant bit (serial output)
module seq_piso #(
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  output logic              msb
);

  logic [WORD_W-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[WORD_W-2:0], 1'b0};
    end
  end

  assign msb = sr[WORD_W-1];

endmodule

// File: rtl/seq_detect_ctrl.sv
// Sequencer for a Moore 4-in-a-row run detector. Accepts a word over
// in_valid/in_ready, serializes it MSB-first onto det_w, collects det_z
// one cycle behind each bit, and returns hit/count/first-index results
// over out_valid/out_ready. The detector is held cleared between words.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   in_valid, in_ready, in_data : input word handshake
//   det_w, det_clr, det_z       : detector serial input, clear, response
//   out_valid, out_ready        : result handshake
//   out_hit, out_count, out_first : per-word result fields
//   busy                        : controller not in IDLE
import seq_ctrl_pkg::*;

module seq_detect_ctrl #(
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter int unsigned CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              det_w,
  output logic              det_clr,
  input  logic              det_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_hit,
  output logic [CNT_W-1:0]  out_count,
  output logic [CNT_W-1:0]  out_first,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

  ctrl_state_t      state, state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic             acc_hit, hit_nxt;
  logic [CNT_W-1:0] acc_count, count_nxt;
  logic [CNT_W-1:0] acc_first, first_nxt;
  logic             load, shift, samp_en;
  logic [CNT_W-1:0] samp_idx;
  logic             piso_msb;
  logic             det_clr_q;

  seq_piso #(.WORD_W(WORD_W)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (in_data),
    .msb   (piso_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    samp_en   = 1'b0;
    samp_idx  = '0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        // z lags w by one cycle: the sample in cycle j belongs to bit j-1.
        samp_en  = (bit_cnt != '0);
        samp_idx = bit_cnt - CNT_W'(1);
        if (bit_cnt == LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        samp_en   = 1'b1;
        samp_idx  = LAST;
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    hit_nxt   = acc_hit;
    count_nxt = acc_count;
    first_nxt = acc_first;
    if (samp_en && det_z) begin
      count_nxt = acc_count + CNT_W'(1);
      if (!acc_hit) begin
        hit_nxt   = 1'b1;
        first_nxt = samp_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det_clr_q <= 1'b1;
      bit_cnt   <= '0;
      acc_hit   <= 1'b0;
      acc_count <= '0;
      acc_first <= '0;
      out_hit   <= 1'b0;
      out_count <= '0;
      out_first <= '0;
    end else begin
      // Registered so the detector clear never glitches.
      det_clr_q <= (state_nxt == IDLE) || (state_nxt == DONE);
      if (load) begin
        bit_cnt   <= '0;
        acc_hit   <= 1'b0;
        acc_count <= '0;
        acc_first <= '0;
      end else begin
        if (state == SHIFT) bit_cnt <= bit_cnt + CNT_W'(1);
        acc_hit   <= hit_nxt;
        acc_count <= count_nxt;
        acc_first <= first_nxt;
      end
      // Results include the final DRAIN sample and hold until the next word.
      if (state == DRAIN) begin
        out_hit   <= hit_nxt;
        out_count <= count_nxt;
        out_first <= first_nxt;
      end
    end
  end

  assign det_clr   = det_clr_q;
  assign det_w     = (state == SHIFT) && piso_msb;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_detect_ctrl.sv
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       det_w;
  logic       det_clr;
  logic       det_z;
  logic       out_valid;
  logic       out_ready;
  logic       out_hit;
  logic [3:0] out_count;
  logic [3:0] out_first;
  logic       busy;

  int tests = 0;
  int fails = 0;

  seq_detect_ctrl #(.WORD_W(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .det_w     (det_w),
    .det_clr   (det_clr),
    .det_z     (det_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hit   (out_hit),
    .out_count (out_count),
    .out_first (out_first),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Moore run detector: state A after clear, z=1 once the last four or
  // more bits are equal. rst_n = ~det_clr.
  logic [2:0] run;
  logic       last;
  always @(posedge clk or posedge det_clr) begin
    if (det_clr) begin
      run  <= 3'd0;
      last <= 1'b0;
    end else if (run == 3'd0 || det_w != last) begin
      last <= det_w;
      run  <= 3'd1;
    end else if (run != 3'd4) begin
      run <= run + 3'd1;
    end
  end
  assign det_z = (run == 3'd4);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] d);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Called in SHIFT cycle 0; returns cycles until out_valid and the serial stream.
  task automatic collect(output int lat, output logic [7:0] ser, output int ones);
    lat  = 0;
    ser  = '0;
    ones = 0;
    while (!out_valid && lat < 30) begin
      if (lat < 8) ser = {ser[6:0], det_w};
      ones += int'(det_w);
      tick();
      lat++;
    end
    check("valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic run_word(input string tag, input logic [7:0] d,
                          input logic hit, input int cnt, input int first);
    int lat, ones;
    logic [7:0] ser;
    accept(d);
    check({tag, "_clr_low"}, {31'd0, det_clr}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    collect(lat, ser, ones);
    check({tag, "_latency"}, lat, 32'd9);
    check({tag, "_serial"}, {24'd0, ser}, {24'd0, d});
    check({tag, "_ones"}, ones, $countones(d));
    check({tag, "_hit"}, {31'd0, out_hit}, {31'd0, hit});
    check({tag, "_count"}, {28'd0, out_count}, cnt);
    check({tag, "_first"}, {28'd0, out_first}, first);
    tick();
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_idle_clr"}, {31'd0, det_clr}, 32'd1);
    check({tag, "_count_held"}, {28'd0, out_count}, cnt);
  endtask

  initial begin : stim
    int lat, ones;
    logic [7:0] ser;
    logic seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_det_clr", {31'd0, det_clr}, 32'd1);
    check("rst_det_w", {31'd0, det_w}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fields", {23'd0, out_hit, out_count, out_first}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    run_word("w00", 8'h00, 1'b1, 5, 3);
    run_word("wFF", 8'hFF, 1'b1, 5, 3);
    run_word("w0F", 8'h0F, 1'b1, 2, 3);
    run_word("w55", 8'h55, 1'b0, 0, 0);
    run_word("w33", 8'h33, 1'b0, 0, 0);

    // Back-pressure in DONE with a word offered meanwhile.
    out_ready = 1'b0;
    accept(8'hF0);
    collect(lat, ser, ones);
    check("hold_latency", lat, 32'd9);
    check("hold_hit", {31'd0, out_hit}, 32'd1);
    in_data  = 8'h0F;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_count", {28'd0, out_count}, 32'd2);
      check("hold_first", {28'd0, out_first}, 32'd3);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("hs_idle_ready", {31'd0, in_ready}, 32'd1);
    check("hs_valid_drop", {31'd0, out_valid}, 32'd0);
    check("hs_idle_clr", {31'd0, det_clr}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("late_accept_busy", {31'd0, busy}, 32'd1);
    check("late_accept_ready", {31'd0, in_ready}, 32'd0);
    collect(lat, ser, ones);
    check("late_latency", lat, 32'd9);
    check("late_serial", {24'd0, ser}, 32'h0F);
    check("late_count", {28'd0, out_count}, 32'd2);
    check("late_first", {28'd0, out_first}, 32'd3);
    tick();

    // Reset in SHIFT cycle 4 aborts the word.
    accept(8'h00);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    #1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_det_clr", {31'd0, det_clr}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_det_w", {31'd0, det_w}, 32'd0);
    check("abort_fields", {23'd0, out_hit, out_count, out_first}, 32'd0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen |= out_valid;
    end
    check("abort_no_valid", {31'd0, seen}, 32'd0);
    run_word("post_rst_FF", 8'hFF, 1'b1, 5, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
